pll_lock_seq: RTL and testbench



---
 rtl/pll_lock_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_seq.sv | 166 ++++++++++++++++
 tb/tb_pll_lock_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_lock_seq_pkg                                                      |
// | State encodings and widths shared by the PLL reset/lock sequencer.   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package pll_lock_seq_pkg;

    localparam int STATE_W = 3;
    localparam int STATS_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

endpackage : pll_lock_seq_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff                                                              |
// | Generic two-flop bit synchronizer with async active-low reset.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_lock_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_lock_seq                                                          |
// | PLL reset pulse, lock qualification, auto-retry and hard-fail flag.  |
// | Optional relock statistics port: define PLL_LOCK_SEQ_STATS_EN.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module pll_lock_seq
    import pll_lock_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               ready,
    output logic               fail,
    output logic               lock_lost,
    output logic [STATE_W-1:0] state
`ifdef PLL_LOCK_SEQ_STATS_EN
    ,
    output logic [STATS_W-1:0] relock_count
`endif
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [RETRY_W-1:0] r_retries, w_retries_nxt, w_retry_inc;
    logic               w_lock_s;
    logic               w_loss;
    logic               r_pll_rst, r_ready, r_fail, r_lock_lost;
    logic               w_pll_rst, w_ready, w_fail;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_lock_s)
    );

    // Counter holds at all-ones rather than wrapping back into a short window.
    assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_retry_inc = r_retries + 1'b1;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_retries   <= '0;
            r_pll_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retries   <= w_retries_nxt;
            r_pll_rst   <= w_pll_rst;
            r_ready     <= w_ready;
            r_fail      <= w_fail;
            r_lock_lost <= w_loss;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retries_nxt = r_retries;
        w_loss        = 1'b0;
        if (restart) begin
            w_state_nxt   = ST_RST;
            w_cnt_nxt     = '0;
            w_retries_nxt = '0;
        end else begin
            case (r_state)
                ST_RST: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_WAIT: begin
                    // A lock seen on the timeout cycle still counts as a lock.
                    if (w_lock_s) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        w_retries_nxt = w_retry_inc;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = (w_retry_inc == RETRY_W'(MAX_RETRIES)) ? ST_FAIL : ST_RST;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        w_state_nxt   = ST_RUN;
                        w_cnt_nxt     = '0;
                        w_retries_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_loss      = 1'b1;
                        w_state_nxt = ST_RST;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_RST;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_pll_rst = (w_state_nxt == ST_RST) || (w_state_nxt == ST_FAIL);
        w_ready   = (w_state_nxt == ST_RUN);
        w_fail    = (w_state_nxt == ST_FAIL);
    end

    assign pll_rst   = r_pll_rst;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign lock_lost = r_lock_lost;
    assign state     = r_state;

`ifdef PLL_LOCK_SEQ_STATS_EN
    logic               w_timeout;
    logic [STATS_W-1:0] r_relock_cnt;

    assign w_timeout = !restart && (r_state == ST_WAIT) && !w_lock_s
                     && (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_relock_cnt <= '0;
        end else if ((w_timeout || w_loss) && (r_relock_cnt != {STATS_W{1'b1}})) begin
            r_relock_cnt <= r_relock_cnt + 1'b1;
        end
    end

    assign relock_count = r_relock_cnt;
`endif

endmodule : pll_lock_seq
`default_nettype wire

// File: tb/tb_pll_lock_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pll_lock_seq                                                       |
// | Directed scoreboard bench for pll_lock_seq (4/20/8/3 configuration). |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_pll_lock_seq;

    localparam int SIG_PLL_RST = 0;
    localparam int SIG_READY   = 1;
    localparam int SIG_FAIL    = 2;
    localparam int SIG_LOST    = 3;
    localparam int SIG_STATE   = 4;
    localparam int SIG_RELOCK  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst, ready, fail, lock_lost;
    logic [2:0] state;
`ifdef PLL_LOCK_SEQ_STATS_EN
    logic [7:0] relock_count;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         due;
        string      tag;
        int         sig;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];

    pll_lock_seq #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .CNT_W         (16)
    ) dut (
        .refclk     (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .state      (state)
`ifdef PLL_LOCK_SEQ_STATS_EN
        ,
        .relock_count (relock_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sel(int s);
        case (s)
            SIG_PLL_RST: return {7'd0, pll_rst};
            SIG_READY:   return {7'd0, ready};
            SIG_FAIL:    return {7'd0, fail};
            SIG_LOST:    return {7'd0, lock_lost};
            SIG_STATE:   return {5'd0, state};
`ifdef PLL_LOCK_SEQ_STATS_EN
            SIG_RELOCK:  return relock_count;
`endif
            default:     return 8'hxx;
        endcase
    endfunction

    // Retire every expectation that falls due in the cycle just completed.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                assert (sel(sb[i].sig) === sb[i].exp)
                else begin
                    errors++;
                    $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                           sb[i].tag, cyc, sel(sb[i].sig), sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(int k, string tag, int sig, logic [7:0] v);
        exp_t e;
        e.due = cyc + k;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        step(1);

        checks++;
        if (pll_rst !== 1'b1) begin
            errors++;
            $error("FAIL inrst_pll_rst observed=%0b expected=1", pll_rst);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $error("FAIL inrst_ready observed=%0b expected=0", ready);
        end
        checks++;
        if (fail !== 1'b0) begin
            errors++;
            $error("FAIL inrst_fail observed=%0b expected=0", fail);
        end
        checks++;
        if (lock_lost !== 1'b0) begin
            errors++;
            $error("FAIL inrst_lost observed=%0b expected=0", lock_lost);
        end
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $error("FAIL inrst_state observed=%0h expected=0", state);
        end

        // Reset values
        expect_at(1, "rst_pll_rst", SIG_PLL_RST, 8'd1);
        expect_at(1, "rst_ready",   SIG_READY,   8'd0);
        expect_at(1, "rst_fail",    SIG_FAIL,    8'd0);
        expect_at(1, "rst_lost",    SIG_LOST,    8'd0);
        expect_at(1, "rst_state",   SIG_STATE,   8'd0);
        step(2);

        // 1. Power-up
        rst_n = 1'b1;
        expect_at(3, "pu_pll_rst_hi", SIG_PLL_RST, 8'd1);
        expect_at(4, "pu_pll_rst_lo", SIG_PLL_RST, 8'd0);
        expect_at(4, "pu_state_wait", SIG_STATE,   8'd1);
        step(10);
        pll_locked = 1'b1;
        expect_at(3,  "pu_state_stable", SIG_STATE, 8'd2);
        expect_at(10, "pu_ready_early",  SIG_READY, 8'd0);
        expect_at(11, "pu_ready_rise",   SIG_READY, 8'd1);
        expect_at(11, "pu_fail",         SIG_FAIL,  8'd0);
        expect_at(11, "pu_state_run",    SIG_STATE, 8'd3);
        step(12);

        // 3. Lock loss while running
        pll_locked = 1'b0;
        expect_at(2, "loss_lost_early", SIG_LOST,    8'd0);
        expect_at(3, "loss_lost_pulse", SIG_LOST,    8'd1);
        expect_at(4, "loss_lost_clear", SIG_LOST,    8'd0);
        expect_at(2, "loss_ready_hold", SIG_READY,   8'd1);
        expect_at(3, "loss_ready_drop", SIG_READY,   8'd0);
        expect_at(3, "loss_state_rst",  SIG_STATE,   8'd0);
        expect_at(6, "loss_pll_rst_hi", SIG_PLL_RST, 8'd1);
        expect_at(7, "loss_pll_rst_lo", SIG_PLL_RST, 8'd0);
        expect_at(7, "loss_state_wait", SIG_STATE,   8'd1);
`ifdef PLL_LOCK_SEQ_STATS_EN
        expect_at(3, "loss_relock", SIG_RELOCK, 8'd1);
`endif
        step(7);

        // 2. Lock chatter during STABLE, then relock
        pll_locked = 1'b1;
        expect_at(3, "chat_state_stable", SIG_STATE, 8'd2);
        step(5);
        pll_locked = 1'b0;
        expect_at(3, "chat_state_wait", SIG_STATE, 8'd1);
        step(2);
        pll_locked = 1'b1;
        expect_at(3,  "chat_state_stable2", SIG_STATE, 8'd2);
        expect_at(10, "chat_ready_early",   SIG_READY, 8'd0);
        expect_at(11, "chat_ready_rise",    SIG_READY, 8'd1);
        step(12);

        // 4. PLL never locks: three attempts then hard failure
        pll_locked = 1'b0;
        expect_at(3,  "nl_lost_pulse",  SIG_LOST,    8'd1);
        expect_at(26, "nl_wait1_end",   SIG_STATE,   8'd1);
        expect_at(27, "nl_retry1",      SIG_STATE,   8'd0);
        expect_at(27, "nl_retry1_rst",  SIG_PLL_RST, 8'd1);
        expect_at(50, "nl_wait2_end",   SIG_STATE,   8'd1);
        expect_at(51, "nl_retry2",      SIG_STATE,   8'd0);
        expect_at(74, "nl_wait3_end",   SIG_STATE,   8'd1);
        expect_at(74, "nl_fail_early",  SIG_FAIL,    8'd0);
        expect_at(75, "nl_state_fail",  SIG_STATE,   8'd4);
        expect_at(75, "nl_fail_set",    SIG_FAIL,    8'd1);
        expect_at(75, "nl_pll_rst",     SIG_PLL_RST, 8'd1);
        expect_at(79, "nl_fail_hold",   SIG_FAIL,    8'd1);
        expect_at(79, "nl_rst_hold",    SIG_PLL_RST, 8'd1);
        expect_at(79, "nl_ready_low",   SIG_READY,   8'd0);
`ifdef PLL_LOCK_SEQ_STATS_EN
        expect_at(74, "nl_relock_4", SIG_RELOCK, 8'd4);
        expect_at(75, "nl_relock_5", SIG_RELOCK, 8'd5);
`endif
        step(80);

        // 5. Recovery from FAIL via restart
        pll_locked = 1'b1;
        step(5);
        expect_at(1, "rec_state_fail", SIG_STATE, 8'd4);
        step(1);
        restart = 1'b1;
        expect_at(1,  "rec_fail_clear", SIG_FAIL,    8'd0);
        expect_at(1,  "rec_state_rst",  SIG_STATE,   8'd0);
        expect_at(4,  "rec_pll_rst_hi", SIG_PLL_RST, 8'd1);
        expect_at(5,  "rec_pll_rst_lo", SIG_PLL_RST, 8'd0);
        expect_at(6,  "rec_stable",     SIG_STATE,   8'd2);
        expect_at(13, "rec_ready_early", SIG_READY,  8'd0);
        expect_at(14, "rec_ready_rise", SIG_READY,   8'd1);
        step(1);
        restart = 1'b0;
        step(14);

        // 6. Restart coincident with lock loss in RUN
        pll_locked = 1'b0;
        step(2);
        restart = 1'b1;
        expect_at(1, "sim_lost_none",  SIG_LOST,  8'd0);
        expect_at(2, "sim_lost_none2", SIG_LOST,  8'd0);
        expect_at(1, "sim_state_rst",  SIG_STATE, 8'd0);
        expect_at(1, "sim_ready_low",  SIG_READY, 8'd0);
        expect_at(1, "sim_fail_low",   SIG_FAIL,  8'd0);
`ifdef PLL_LOCK_SEQ_STATS_EN
        expect_at(2, "sim_relock_same", SIG_RELOCK, 8'd5);
`endif
        step(1);
        restart = 1'b0;
        step(1);

`ifdef PLL_LOCK_SEQ_STATS_EN
        // Forced repeated losses drive the statistics counter into saturation
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b1;
            step(20);
            pll_locked = 1'b0;
            step(4);
        end
        expect_at(1, "stats_saturate", SIG_RELOCK, 8'd255);
`endif
        step(3);

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s never retired due=%0d observed=none expected=%0h",
                     sb[0].tag, sb[0].due, sb[0].exp);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pll_lock_seq
`default_nettype wire
